// File: rtl/cpu_ram_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the RAM port.
// Latency: none; this is wiring only.
// Backpressure: none; requesters hold req and payload until their done pulse.
interface cpu_ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;

  // Data load/store requester
  logic              d_req;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;

  // Single shared RAM port
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic              ram_ren;
  logic              ram_wen;
  logic [DATA_W-1:0] ram_load;

  // Arbiter view: takes requests and RAM read data, drives RAM and responses
  modport slave (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, ram_load,
    output i_rdata, i_done, d_rdata, d_done,
    output ram_addr, ram_store, ram_ren, ram_wen
  );

  // Requester/RAM-model view: the mirror of the arbiter view
  modport master (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, ram_load,
    input  i_rdata, i_done, d_rdata, d_done,
    input  ram_addr, ram_store, ram_ren, ram_wen
  );
endinterface

// File: rtl/cpu_ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between instruction fetch (I) and data (D).
// Latency: grant in IDLE, RAM_LAT ACCESS cycles, then a one-cycle done pulse (RAM_LAT+2 per access).
// Backpressure: requesters hold req/payload until done; inputs are ignored outside IDLE.
module cpu_ram_arbiter #(
  parameter int RAM_LAT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                    ram_clk,
  input  logic                    rst,
  cpu_ram_arbiter_if.slave        bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Owner / last-grant encoding: 0 = fetch port, 1 = data port
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [3:0] CNT_INIT = 4'(RAM_LAT - 1);

  logic [1:0]        state_q,      state_d;
  logic [3:0]        cnt_q,        cnt_d;
  logic              owner_q,      owner_d;
  logic              last_grant_q, last_grant_d;
  logic              wen_q,        wen_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;
  logic [DATA_W-1:0] i_rdata_q,    i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;

  logic              grant_d;
  logic              in_access;
  logic              in_resp;

  // D wins if it is the only requester, or if both request and I was served last
  always_comb begin
    grant_d = bus.d_req && (!bus.i_req || (last_grant_q == OWN_I));
  end

  // Next-state logic: arbitration in IDLE, latency countdown in ACCESS, one-cycle RESP
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          owner_d      = grant_d ? OWN_D : OWN_I;
          last_grant_d = grant_d ? OWN_D : OWN_I;
          addr_d       = grant_d ? bus.d_addr : bus.i_addr;
          wdata_d      = grant_d ? bus.d_wdata : '0;
          wen_d        = grant_d && bus.d_wen;
          cnt_d        = CNT_INIT;
          state_d      = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Last ACCESS cycle: RAM data is valid now, stores leave rdata alone
          if (!wen_q) begin
            if (owner_q == OWN_D) begin
              d_rdata_d = bus.ram_load;
            end else begin
              i_rdata_d = bus.ram_load;
            end
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; async reset so the RAM strobes drop the moment rst rises
  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // RAM port and done pulses decode straight from the registered state
  always_comb begin
    in_access     = (state_q == ST_ACCESS);
    in_resp       = (state_q == ST_RESP);
    bus.ram_ren   = in_access && !wen_q;
    bus.ram_wen   = in_access && wen_q;
    bus.ram_addr  = in_access ? addr_q : '0;
    bus.ram_store = (in_access && wen_q) ? wdata_q : '0;
    bus.i_done    = in_resp && (owner_q == OWN_I);
    bus.d_done    = in_resp && (owner_q == OWN_D);
    bus.i_rdata   = i_rdata_q;
    bus.d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_cpu_ram_arbiter.sv
// Directed bench for cpu_ram_arbiter: per-cycle vector table on a RAM_LAT=2 build,
// plus a hand sequence on a RAM_LAT=1 build and continuous exclusivity checks.
module tb_cpu_ram_arbiter;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;
  localparam logic [31:0] DB  = 32'hDEADBEEF;
  localparam logic [31:0] D1  = 32'h12345678;
  localparam logic [31:0] BF  = 32'h0BADF00D;
  localparam logic [31:0] GRB = 32'h5A5A5A5A;

  logic ram_clk;
  logic rst;
  logic mem_clr;

  int checks;
  int errors;

  cpu_ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  cpu_ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  cpu_ram_arbiter #(.RAM_LAT(LAT0), .ADDR_W(32), .DATA_W(32)) u_dut0 (
    .ram_clk (ram_clk),
    .rst     (rst),
    .bus     (bus0)
  );

  cpu_ram_arbiter #(.RAM_LAT(LAT1), .ADDR_W(32), .DATA_W(32)) u_dut1 (
    .ram_clk (ram_clk),
    .rst     (rst),
    .bus     (bus1)
  );

  initial ram_clk = 1'b0;
  always #5 ram_clk = ~ram_clk;

  // ---------------- RAM models ----------------
  function automatic logic [31:0] init_word(input logic [9:0] idx);
    case (idx)
      10'd64:  return DB;   // 0x100
      10'd128: return BF;   // 0x200
      default: return 32'h0;
    endcase
  endfunction

  logic [31:0]   wr_dat [1024];
  logic [1023:0] wr_vld;
  logic [3:0]    ren_run0;
  logic [9:0]    idx0;
  logic [9:0]    idx1;
  logic [31:0]   word0;

  assign idx0  = bus0.ram_addr[11:2];
  assign idx1  = bus1.ram_addr[11:2];
  assign word0 = wr_vld[idx0] ? wr_dat[idx0] : init_word(idx0);

  always @(posedge ram_clk) begin
    if (mem_clr) begin
      wr_vld <= '0;
    end else if (bus0.ram_wen) begin
      wr_dat[idx0] <= bus0.ram_store;
      wr_vld[idx0] <= 1'b1;
    end
    ren_run0 <= bus0.ram_ren ? (ren_run0 + 4'd1) : 4'd0;
  end

  // Data valid only once ren has been held for the full latency
  assign bus0.ram_load = (bus0.ram_ren && (ren_run0 == 4'(LAT0 - 1))) ? word0 : GRB;
  assign bus1.ram_load = bus1.ram_ren ? init_word(idx1) : GRB;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  // Done pulses and RAM strobes must never collide on either build
  always @(negedge ram_clk) begin
    if (!rst) begin
      checks++;
      if ((bus0.i_done && bus0.d_done) || (bus0.ram_ren && bus0.ram_wen) ||
          (bus1.i_done && bus1.d_done) || (bus1.ram_ren && bus1.ram_wen)) begin
        errors++;
        $display("FAIL exclusivity at %0t: dut0 dn=%b%b rw=%b%b dut1 dn=%b%b rw=%b%b", $time,
                 bus0.i_done, bus0.d_done, bus0.ram_ren, bus0.ram_wen,
                 bus1.i_done, bus1.d_done, bus1.ram_ren, bus1.ram_wen);
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic        e_idone;
    logic        e_ddone;
    logic [31:0] e_irdata;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t row(
    input logic r, input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
    input logic ren, input logic wen, input logic [31:0] ra, input logic [31:0] rs,
    input logic idn, input logic ddn, input logic [31:0] ird, input logic [31:0] drd);
    vec_t v;
    v.rst = r;  v.i_req = ir; v.i_addr = ia;
    v.d_req = dr; v.d_wen = dw; v.d_addr = da; v.d_wdata = dd;
    v.e_ren = ren; v.e_wen = wen; v.e_addr = ra; v.e_store = rs;
    v.e_idone = idn; v.e_ddone = ddn; v.e_irdata = ird; v.e_drdata = drd;
    return v;
  endfunction

  int done_cyc;
  int ren_cnt;
  logic [31:0] rdat1;

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    mem_clr = 1'b1;
    bus0.i_req = 1'b0; bus0.i_addr = '0; bus0.d_req = 1'b0;
    bus0.d_wen = 1'b0; bus0.d_addr = '0; bus0.d_wdata = '0;
    bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0;
    bus1.d_wen = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;

    //               rst ir ia      dr dw da      dd  | ren wen addr    store idn ddn irdata drdata
    // Reset state
    vq.push_back(row(1, 0, 32'h0,   0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   0, 0, 0,  0));
    // I read of 0x100: ACCESS cycles 1-2, done cycle 3
    vq.push_back(row(0, 1, 32'h100, 0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   0, 0, 0,  0));
    vq.push_back(row(0, 1, 32'h100, 0, 0, 32'h0,   0,   1, 0, 32'h100, 0,   0, 0, 0,  0));
    vq.push_back(row(0, 1, 32'h100, 0, 0, 32'h0,   0,   1, 0, 32'h100, 0,   0, 0, 0,  0));
    vq.push_back(row(0, 1, 32'h100, 0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   1, 0, DB, 0));
    vq.push_back(row(0, 0, 32'h0,   0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   0, 0, DB, 0));
    // D store 0x12345678 to 0x40; d_rdata must stay 0
    vq.push_back(row(0, 0, 32'h0,   1, 1, 32'h40,  D1,  0, 0, 32'h0,   0,   0, 0, DB, 0));
    vq.push_back(row(0, 0, 32'h0,   1, 1, 32'h40,  D1,  0, 1, 32'h40,  D1,  0, 0, DB, 0));
    vq.push_back(row(0, 0, 32'h0,   1, 1, 32'h40,  D1,  0, 1, 32'h40,  D1,  0, 0, DB, 0));
    vq.push_back(row(0, 0, 32'h0,   1, 1, 32'h40,  D1,  0, 0, 32'h0,   0,   0, 1, DB, 0));
    vq.push_back(row(0, 0, 32'h0,   0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   0, 0, DB, 0));
    // D load back from 0x40
    vq.push_back(row(0, 0, 32'h0,   1, 0, 32'h40,  0,   0, 0, 32'h0,   0,   0, 0, DB, 0));
    vq.push_back(row(0, 0, 32'h0,   1, 0, 32'h40,  0,   1, 0, 32'h40,  0,   0, 0, DB, 0));
    vq.push_back(row(0, 0, 32'h0,   1, 0, 32'h40,  0,   1, 0, 32'h40,  0,   0, 0, DB, 0));
    vq.push_back(row(0, 0, 32'h0,   1, 0, 32'h40,  0,   0, 0, 32'h0,   0,   0, 1, DB, D1));
    vq.push_back(row(0, 0, 32'h0,   0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   0, 0, DB, D1));
    // Reset, then both held: order D, I, D, I with dones at relative cycles 3, 7, 11, 15
    vq.push_back(row(1, 0, 32'h0,   0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   0, 0, 0,  0));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   0, 0, 32'h0,   0,   0, 0, 0,  0));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   1, 0, 32'h40,  0,   0, 0, 0,  0));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   1, 0, 32'h40,  0,   0, 0, 0,  0));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   0, 0, 32'h0,   0,   0, 1, 0,  D1));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   0, 0, 32'h0,   0,   0, 0, 0,  D1));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   1, 0, 32'h100, 0,   0, 0, 0,  D1));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   1, 0, 32'h100, 0,   0, 0, 0,  D1));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   0, 0, 32'h0,   0,   1, 0, DB, D1));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   0, 0, 32'h0,   0,   0, 0, DB, D1));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   1, 0, 32'h40,  0,   0, 0, DB, D1));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   1, 0, 32'h40,  0,   0, 0, DB, D1));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   0, 0, 32'h0,   0,   0, 1, DB, D1));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   0, 0, 32'h0,   0,   0, 0, DB, D1));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   1, 0, 32'h100, 0,   0, 0, DB, D1));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   1, 0, 32'h100, 0,   0, 0, DB, D1));
    vq.push_back(row(0, 1, 32'h100, 1, 0, 32'h40,  0,   0, 0, 32'h0,   0,   1, 0, DB, D1));
    vq.push_back(row(0, 0, 32'h0,   0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   0, 0, DB, D1));
    // D held from cycle 0 (load 0x200), I raised in cycle 1 (load 0x40): I done at cycle 7
    vq.push_back(row(0, 0, 32'h0,   1, 0, 32'h200, 0,   0, 0, 32'h0,   0,   0, 0, DB, D1));
    vq.push_back(row(0, 1, 32'h40,  1, 0, 32'h200, 0,   1, 0, 32'h200, 0,   0, 0, DB, D1));
    vq.push_back(row(0, 1, 32'h40,  1, 0, 32'h200, 0,   1, 0, 32'h200, 0,   0, 0, DB, D1));
    vq.push_back(row(0, 1, 32'h40,  1, 0, 32'h200, 0,   0, 0, 32'h0,   0,   0, 1, DB, BF));
    vq.push_back(row(0, 1, 32'h40,  1, 0, 32'h200, 0,   0, 0, 32'h0,   0,   0, 0, DB, BF));
    vq.push_back(row(0, 1, 32'h40,  1, 0, 32'h200, 0,   1, 0, 32'h40,  0,   0, 0, DB, BF));
    vq.push_back(row(0, 1, 32'h40,  1, 0, 32'h200, 0,   1, 0, 32'h40,  0,   0, 0, DB, BF));
    vq.push_back(row(0, 1, 32'h40,  0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   1, 0, D1, BF));
    vq.push_back(row(0, 0, 32'h0,   0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   0, 0, D1, BF));
    // I read, rst in cycle 2: strobes drop at once, no done, rdata cleared; held req restarts
    vq.push_back(row(0, 1, 32'h100, 0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   0, 0, D1, BF));
    vq.push_back(row(0, 1, 32'h100, 0, 0, 32'h0,   0,   1, 0, 32'h100, 0,   0, 0, D1, BF));
    vq.push_back(row(1, 1, 32'h100, 0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   0, 0, 0,  0));
    vq.push_back(row(0, 1, 32'h100, 0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   0, 0, 0,  0));
    vq.push_back(row(0, 1, 32'h100, 0, 0, 32'h0,   0,   1, 0, 32'h100, 0,   0, 0, 0,  0));
    // req dropped and address changed mid-access: no effect, access completes
    vq.push_back(row(0, 0, 32'h40,  0, 0, 32'h0,   0,   1, 0, 32'h100, 0,   0, 0, 0,  0));
    vq.push_back(row(0, 0, 32'h0,   0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   1, 0, DB, 0));
    vq.push_back(row(0, 0, 32'h0,   0, 0, 32'h0,   0,   0, 0, 32'h0,   0,   0, 0, DB, 0));

    for (int k = 0; k < vq.size(); k++) begin
      @(posedge ram_clk);
      #1;
      if (k > 0) mem_clr = 1'b0;
      rst          = vq[k].rst;
      bus0.i_req   = vq[k].i_req;
      bus0.i_addr  = vq[k].i_addr;
      bus0.d_req   = vq[k].d_req;
      bus0.d_wen   = vq[k].d_wen;
      bus0.d_addr  = vq[k].d_addr;
      bus0.d_wdata = vq[k].d_wdata;
      @(negedge ram_clk);
      chk("ram_ren",   k, 32'(bus0.ram_ren), 32'(vq[k].e_ren));
      chk("ram_wen",   k, 32'(bus0.ram_wen), 32'(vq[k].e_wen));
      chk("ram_addr",  k, bus0.ram_addr,     vq[k].e_addr);
      chk("ram_store", k, bus0.ram_store,    vq[k].e_store);
      chk("i_done",    k, 32'(bus0.i_done),  32'(vq[k].e_idone));
      chk("d_done",    k, 32'(bus0.d_done),  32'(vq[k].e_ddone));
      chk("i_rdata",   k, bus0.i_rdata,      vq[k].e_irdata);
      chk("d_rdata",   k, bus0.d_rdata,      vq[k].e_drdata);
    end

    // RAM_LAT=1 build: single read of 0x200, ren for one cycle, done in cycle 2
    done_cyc = -1;
    ren_cnt  = 0;
    rdat1    = '0;
    @(posedge ram_clk);
    #1;
    bus1.i_req  = 1'b1;
    bus1.i_addr = 32'h200;
    for (int c = 0; c < 10; c++) begin
      @(negedge ram_clk);
      if (bus1.ram_ren) ren_cnt++;
      if (bus1.i_done && done_cyc < 0) begin
        done_cyc = c;
        rdat1    = bus1.i_rdata;
      end
      @(posedge ram_clk);
      #1;
      if (done_cyc >= 0) bus1.i_req = 1'b0;
    end
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL lat1_timeout: no i_done within 10 cycles, required cycle 2");
    end else begin
      chk("lat1_done_cycle", 0, 32'(done_cyc), 32'd2);
      chk("lat1_rdata",      0, rdat1,         BF);
    end
    chk("lat1_ren_cycles", 0, 32'(ren_cnt), 32'd1);
    chk("lat1_d_done_idle", 0, 32'(bus1.d_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
